// File: rtl/vc_allocator_pkg.sv
// Shared sizing and types for the virtual-channel allocator.
package vc_allocator_pkg;

   localparam int unsigned in_Port_Cnt = 5;
   localparam int unsigned vc_Num      = 4;
   localparam int unsigned VC_IDX_W    = $clog2(vc_Num);
   localparam int unsigned PORT_IDX_W  = $clog2(in_Port_Cnt);
   localparam int unsigned FLAT_N      = in_Port_Cnt * vc_Num;
   localparam int unsigned FLAT_IDX_W  = $clog2(FLAT_N);

   typedef logic [PORT_IDX_W-1:0] inout_Port;
   typedef logic [VC_IDX_W-1:0]   vc_idx_t;

   // Flattened input-VC index used for round-robin ordering.
   function automatic int unsigned flat_idx(input int unsigned p, input int unsigned v);
      return p * vc_Num + v;
   endfunction

endpackage

// File: rtl/va_out_arbiter.sv
// Per-output-port round-robin arbiter: picks one requesting input VC and the
// lowest-index free downstream VC; the pointer advances only on a grant.
module va_out_arbiter
   import vc_allocator_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [FLAT_N-1:0] cand_i,
   input  logic [vc_Num-1:0] free_i,
   output logic [FLAT_N-1:0] winner_oh_c,
   output vc_idx_t           alloc_vc_c,
   output logic              valid_c
);

   logic [FLAT_IDX_W-1:0] ptr_q, ptr_d;
   logic [FLAT_IDX_W-1:0] win_idx;
   logic                  cand_any;
   logic                  free_any;
   int unsigned           idx;

   // First candidate at or after the pointer, wrapping around.
   always_comb begin
      cand_any = 1'b0;
      win_idx  = '0;
      idx      = 0;
      for (int unsigned i = 0; i < FLAT_N; i++) begin
         idx = 32'(ptr_q) + i;
         if (idx >= FLAT_N) idx = idx - FLAT_N;
         if (!cand_any && cand_i[FLAT_IDX_W'(idx)]) begin
            cand_any = 1'b1;
            win_idx  = FLAT_IDX_W'(idx);
         end
      end
   end

   always_comb begin
      free_any   = 1'b0;
      alloc_vc_c = '0;
      for (int k = int'(vc_Num) - 1; k >= 0; k--) begin
         if (free_i[k]) begin
            free_any   = 1'b1;
            alloc_vc_c = VC_IDX_W'(k);
         end
      end
   end

   always_comb begin
      valid_c     = cand_any & free_any;
      winner_oh_c = '0;
      ptr_d       = ptr_q;
      if (valid_c) begin
         winner_oh_c[win_idx] = 1'b1;
         ptr_d = (32'(win_idx) == FLAT_N - 1) ? '0 : win_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/vc_allocator.sv
// Virtual-channel allocator: tracks downstream VC ownership and issues
// registered per-input-VC grants, one per output port per cycle.
module vc_allocator
   import vc_allocator_pkg::*;
(
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic [in_Port_Cnt-1:0][vc_Num-1:0]            req_i,
   input  inout_Port [vc_Num-1:0]                        req_out_i [in_Port_Cnt],
   input  logic [in_Port_Cnt-1:0][vc_Num-1:0]            release_i,
   output logic [in_Port_Cnt-1:0][vc_Num-1:0]            grant_o,
   output logic [in_Port_Cnt-1:0][vc_Num-1:0][VC_IDX_W-1:0] grant_vc_o,
   output logic [in_Port_Cnt-1:0][vc_Num-1:0]            out_vc_busy_o
);

   logic [in_Port_Cnt-1:0][vc_Num-1:0]               busy_q, busy_d;
   logic [in_Port_Cnt-1:0][vc_Num-1:0]               grant_q, grant_d;
   logic [in_Port_Cnt-1:0][vc_Num-1:0][VC_IDX_W-1:0] grant_vc_q, grant_vc_d;

   logic [in_Port_Cnt-1:0][FLAT_N-1:0]   cand_c;
   logic [in_Port_Cnt-1:0][vc_Num-1:0]   free_c;
   logic [in_Port_Cnt-1:0][FLAT_N-1:0]   win_oh_c;
   logic [in_Port_Cnt-1:0][VC_IDX_W-1:0] alloc_vc_c;
   logic [in_Port_Cnt-1:0]               valid_c;

   // Masking by grant_q keeps a requester still holding req in its grant cycle from winning twice.
   always_comb begin
      cand_c = '0;
      for (int unsigned o = 0; o < in_Port_Cnt; o++) begin
         for (int unsigned p = 0; p < in_Port_Cnt; p++) begin
            for (int unsigned v = 0; v < vc_Num; v++) begin
               cand_c[o][FLAT_IDX_W'(flat_idx(p, v))] = req_i[p][v] && !grant_q[p][v] &&
                                                      (req_out_i[p][v] == PORT_IDX_W'(o));
            end
         end
      end
      free_c = ~busy_q;
   end

   for (genvar o = 0; o < int'(in_Port_Cnt); o++) begin : g_arb
      va_out_arbiter u_arb (
         .clk         (clk),
         .rst_n       (rst_n),
         .cand_i      (cand_c[o]),
         .free_i      (free_c[o]),
         .winner_oh_c (win_oh_c[o]),
         .alloc_vc_c  (alloc_vc_c[o]),
         .valid_c     (valid_c[o])
      );
   end

   // Releases take effect at the edge; allocation only ever touches free VCs, so no overlap.
   always_comb begin
      grant_d    = '0;
      grant_vc_d = '0;
      busy_d     = busy_q & ~release_i;
      for (int unsigned o = 0; o < in_Port_Cnt; o++) begin
         if (valid_c[o]) begin
            busy_d[o][alloc_vc_c[o]] = 1'b1;
            for (int unsigned p = 0; p < in_Port_Cnt; p++) begin
               for (int unsigned v = 0; v < vc_Num; v++) begin
                  if (win_oh_c[o][FLAT_IDX_W'(flat_idx(p, v))]) begin
                     grant_d[p][v]    = 1'b1;
                     grant_vc_d[p][v] = alloc_vc_c[o];
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q     <= '0;
         grant_q    <= '0;
         grant_vc_q <= '0;
      end else begin
         busy_q     <= busy_d;
         grant_q    <= grant_d;
         grant_vc_q <= grant_vc_d;
      end
   end

   assign grant_o       = grant_q;
   assign grant_vc_o    = grant_vc_q;
   assign out_vc_busy_o = busy_q;

   a_release_busy: assert property (@(posedge clk) disable iff (!rst_n)
      (release_i & ~busy_q) == '0);

   for (genvar p = 0; p < int'(in_Port_Cnt); p++) begin : g_chk_p
      for (genvar v = 0; v < int'(vc_Num); v++) begin : g_chk_v
         a_req_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
            (req_i[p][v] && !grant_q[p][v]) |=> (!req_i[p][v] || $stable(req_out_i[p][v])));
      end
   end

endmodule

// File: tb/tb_vc_allocator.sv
// Directed bench for vc_allocator with hand-computed expected values.
module tb_vc_allocator;
   import vc_allocator_pkg::*;

   logic clk;
   logic rst_n;
   logic [in_Port_Cnt-1:0][vc_Num-1:0]               req;
   inout_Port [vc_Num-1:0]                           req_out [in_Port_Cnt];
   logic [in_Port_Cnt-1:0][vc_Num-1:0]               rel;
   logic [in_Port_Cnt-1:0][vc_Num-1:0]               grant_o;
   logic [in_Port_Cnt-1:0][vc_Num-1:0][VC_IDX_W-1:0] grant_vc_o;
   logic [in_Port_Cnt-1:0][vc_Num-1:0]               out_vc_busy_o;

   int n_checks = 0;
   int n_fail   = 0;

   vc_allocator dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_i         (req),
      .req_out_i     (req_out),
      .release_i     (rel),
      .grant_o       (grant_o),
      .grant_vc_o    (grant_vc_o),
      .out_vc_busy_o (out_vc_busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [1:0] who;
      rst_n = 1'b0;
      req   = '0;
      rel   = '0;
      for (int p = 0; p < int'(in_Port_Cnt); p++) req_out[p] = '0;

      // Reset state
      tick(); tick();
      check("rst_grant", 64'(grant_o), 64'h0);
      check("rst_vc",    64'(grant_vc_o), 64'h0);
      check("rst_busy",  64'(out_vc_busy_o), 64'h0);
      rst_n = 1'b1;
      tick();

      // Traffic, then asynchronous reset mid-cycle
      req[2][1] = 1'b1; req_out[2][1] = 3'd1;
      tick();
      check("pre_rst_grant", 64'(grant_o), 64'h00200);
      check("pre_rst_busy",  64'(out_vc_busy_o), 64'h00010);
      rst_n = 1'b0;
      req   = '0;
      #1;
      check("async_grant", 64'(grant_o), 64'h0);
      check("async_busy",  64'(out_vc_busy_o), 64'h0);
      tick();
      rst_n = 1'b1;
      tick();
      req[0][0] = 1'b1; req_out[0][0] = 3'd1;
      tick();
      check("t1_grant", 64'(grant_o), 64'h00001);
      check("t1_vc",    64'(grant_vc_o[0][0]), 64'h0);
      check("t1_busy",  64'(out_vc_busy_o[1]), 64'h1);
      req = '0;

      // Single request, held through its grant cycle
      req[1][2] = 1'b1; req_out[1][2] = 3'd3;
      tick();
      check("t2_grant", 64'(grant_o), 64'h00040);
      check("t2_vc",    64'(grant_vc_o[1][2]), 64'h0);
      check("t2_busy",  64'(out_vc_busy_o[3]), 64'h1);
      tick();
      check("t2_pulse", 64'(grant_o), 64'h0);
      check("t2_busy_hold", 64'(out_vc_busy_o[3]), 64'h1);
      req = '0;

      // Three contenders on output 4
      req_out[0][0] = 3'd4; req_out[1][0] = 3'd4; req_out[2][0] = 3'd4;
      req[0][0] = 1'b1; req[1][0] = 1'b1; req[2][0] = 1'b1;
      tick();
      check("t3_g0", 64'(grant_o), 64'h00001);
      check("t3_vc0", 64'(grant_vc_o[0][0]), 64'd0);
      req[0][0] = 1'b0;
      tick();
      check("t3_g1", 64'(grant_o), 64'h00010);
      check("t3_vc1", 64'(grant_vc_o[1][0]), 64'd1);
      req[1][0] = 1'b0;
      tick();
      check("t3_g2", 64'(grant_o), 64'h00100);
      check("t3_vc2", 64'(grant_vc_o[2][0]), 64'd2);
      check("t3_busy", 64'(out_vc_busy_o[4]), 64'h7);
      req[2][0] = 1'b0;

      // Fill output 2, block a requester, then free VC 1
      for (int i = 0; i < 4; i++) begin
         req[2][3] = 1'b1; req_out[2][3] = 3'd2;
         tick();
         check("t4_fill_vc", 64'(grant_vc_o[2][3]), 64'(i));
         req[2][3] = 1'b0;
         tick();
      end
      check("t4_full", 64'(out_vc_busy_o[2]), 64'hF);
      req[3][1] = 1'b1; req_out[3][1] = 3'd2;
      tick();
      check("t4_blocked", 64'(grant_o), 64'h0);
      rel[2][1] = 1'b1;
      tick();
      rel = '0;
      check("t4_rel_busy", 64'(out_vc_busy_o[2]), 64'hD);
      check("t4_no_bypass", 64'(grant_o), 64'h0);
      tick();
      check("t4_grant", 64'(grant_o), 64'h02000);
      check("t4_vc", 64'(grant_vc_o[3][1]), 64'd1);
      check("t4_refull", 64'(out_vc_busy_o[2]), 64'hF);
      req = '0;

      // Independent outputs allocate in the same cycle
      rel[1][0] = 1'b1; rel[2] = 4'hF; rel[3][0] = 1'b1;
      tick();
      rel = '0;
      check("t5_cleared", 64'(out_vc_busy_o), 64'h70000);
      req[0][0] = 1'b1; req_out[0][0] = 3'd1;
      req[1][0] = 1'b1; req_out[1][0] = 3'd2;
      req[2][3] = 1'b1; req_out[2][3] = 3'd3;
      tick();
      check("t5_grant", 64'(grant_o), 64'h00811);
      check("t5_vc", 64'(grant_vc_o), 64'h0);
      check("t5_busy", 64'(out_vc_busy_o), 64'h71110);
      req = '0;
      tick();

      // Fairness on output 0 between (0,0) and (4,3), releasing after each grant
      req_out[0][0] = 3'd0; req_out[4][3] = 3'd0;
      req[0][0] = 1'b1; req[4][3] = 1'b1;
      for (int g = 0; g < 6; g++) begin
         tick();
         who = {grant_o[4][3], grant_o[0][0]};
         check("fair_who", 64'(who), (g % 2 == 0) ? 64'h1 : 64'h2);
         check("fair_vc", (g % 2 == 0) ? 64'(grant_vc_o[0][0]) : 64'(grant_vc_o[4][3]), 64'(g % 2));
         rel = '0;
         rel[0][g % 2] = 1'b1;
      end
      req = '0;
      tick();
      rel = '0;
      tick();
      check("end_busy", 64'(out_vc_busy_o), 64'h71110);
      check("end_grant", 64'(grant_o), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
